wmem_store_unit: RTL and testbench
==================================

# wmem_store_unit

Parametrised, buffered store path between the execute/memory stage and the data-memory write port. Accepts store requests (address, data, size) on a valid/ready handshake and queues them in a DEPTH-entry FIFO. Converts each request into word-aligned bus beats with byte strobes. Successor to the combinational store aligner: it adds XLEN generalisation (32/64, doubleword stores), backpressure, buffering, and two-beat splitting of stores that cross a bus-word boundary.

## Interface
Parameters:
- XLEN, 32, data/address width; legal values 32 or 64; bus word = XLEN/8 bytes (NB)
- DEPTH, 4, store FIFO entries; power of two, ≥2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  XLEN  byte address
- req_data  in  XLEN  store data, right-justified
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only)
- bus_valid  out  1  write beat valid
- bus_ready  in  1  memory accepts beat
- bus_addr  out  XLEN  NB-aligned beat address
- bus_wdata  out  XLEN  lane-aligned write data
- bus_wstrb  out  NB  byte-enable mask
- busy  out  1  FIFO non-empty
- misalign_err  out  1  one-cycle pulse: crossing store dropped (macro off only)

## Operation
- Enqueue on req_valid && req_ready; req_ready = !full; no same-cycle bypass of a full FIFO, even if a pop occurs that cycle.
- Head entry: off = addr[log2(NB)-1:0], nbytes = 1<<size. XLEN=32 with size 11 is treated as size 10.
- Form a 2*XLEN shifted value: data << 8*off. Form a 2*NB mask: ((1<<nbytes)-1) << off.
- Beat 0 uses the low halves at addr & ~(NB-1). Beat 1 is needed iff the high mask half is non-zero; it uses the high halves at beat-0 address + NB.
- Unused lanes of bus_wdata are zero.
- FSM states:
  - BEAT0: bus_valid = !empty, carrying beat-0 fields. On handshake, go to BEAT1 if beat 1 is needed; otherwise pop and stay in BEAT0.
  - BEAT1: bus_valid = 1, carrying beat-1 fields. On handshake, pop and go to BEAT0.
- Beat fields are held stable while bus_valid && !bus_ready.
- Simultaneous enqueue and pop when not full: both take effect; occupancy is unchanged.

## Timing
- Reset (async, immediate): FIFO empty, state BEAT0, bus_valid 0, busy 0, misalign_err 0, req_ready 1. bus_addr/wdata/wstrb are 0 while empty.
- Latency: request accepted in cycle N gives bus_valid in cycle N+1.
- Throughput: one non-crossing store per cycle with bus_ready held high; a crossing store takes 2 cycles.
- req_ready deasserts the cycle after the FIFO fills, and reasserts the cycle after a pop.
- Reset during BEAT1 or under backpressure discards all pending entries. No partial second beat is issued after release.

## Configuration
- Macro WMEM_MISALIGNED_SPLIT_EN.
- Defined: crossing stores are split into two beats as above.
- Undefined: no BEAT1 state. A head entry that needs beat 1 is popped in the cycle it reaches BEAT0, with bus_valid 0 and misalign_err 1 for that cycle. Non-crossing stores are unaffected.

## Structure
- Package wmem_pkg holds:
  - size encodings SZ_B, SZ_H, SZ_W, SZ_D
  - FSM state enum (BEAT0, BEAT1)
  - store-entry struct {addr, data, size}
- Sub-module store_fifo: generic DEPTH-entry synchronous FIFO with full/empty flags, using the same async active-low reset.
- Alignment and mask logic stays inline in wmem_store_unit.

## Test plan
- XLEN=32, sb addr 0x1003 data 0xAB → one beat: addr 0x1000, wdata 0xAB000000, wstrb 4'b1000, bus_valid the cycle after accept.
- XLEN=32, sh addr 0x1002 data 0x1234 → addr 0x1000, wdata 0x12340000, wstrb 4'b1100.
- XLEN=32, sw addr 0x2003 data 0xDDCCBBAA:
  - macro on → beat 0: 0x2000/0xAA000000/1000; then beat 1: 0x2004/0x00DDCCBB/0111.
  - macro off → misalign_err pulse, no beat.
- Backpressure: bus_ready low for 3 cycles → beat fields stable. Send DEPTH requests → req_ready 0. One accepted beat → req_ready 1 next cycle.
- XLEN=64, sd addr 0x8 data 0x1122334455667788 → single beat: addr 0x8, wstrb 0xFF, wdata unchanged.
- Reset asserted mid-BEAT1 → bus_valid 0 immediately, busy 0. After release, no beat until a new request.

Source files
------------

// File: rtl/wmem_pkg.sv
// wmem_pkg: shared types for the buffered store path.
//   SZ_B/SZ_H/SZ_W/SZ_D : req_size encodings (byte, half, word, double)
//   state_e             : beat sequencer states (BEAT0, BEAT1)
//   store_entry_t       : one queued store {addr, data, size}, sized for the
//                         widest supported XLEN; narrower builds zero-extend.
package wmem_pkg;

  localparam int unsigned XLEN_MAX = 64;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic {
    BEAT0,
    BEAT1
  } state_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] addr;
    logic [XLEN_MAX-1:0] data;
    logic [1:0]          size;
  } store_entry_t;

endpackage

// File: rtl/store_fifo.sv
// store_fifo: generic DEPTH-entry synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push/wdata : write request; ignored while full (no same-cycle bypass)
//   pop/rdata  : rdata shows the head entry; pop ignored while empty
//   full/empty : occupancy flags, derived from the registered count
module store_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/wmem_store_unit.sv
// wmem_store_unit: buffered store path from the execute/memory stage to the
// data-memory write port. Stores are queued in a DEPTH-entry FIFO and turned
// into NB-aligned bus beats (NB = XLEN/8) with byte strobes.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : store request handshake
//   req_addr/req_data/req_size : byte address, right-justified data, size
//   bus_valid/bus_ready        : write beat handshake
//   bus_addr/bus_wdata/bus_wstrb : aligned beat address, lane data, strobes
//   busy                       : FIFO non-empty
//   misalign_err               : pulse when a crossing store is dropped
// Macro WMEM_MISALIGNED_SPLIT_EN: when defined, stores crossing a bus word
// are split into two beats; otherwise they are dropped with misalign_err.
module wmem_store_unit
  import wmem_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_data,
  input  logic [1:0]        req_size,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [XLEN/8-1:0] bus_wstrb,
  output logic              busy,
  output logic              misalign_err
);

  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  store_entry_t in_entry;
  store_entry_t head;
  logic         full;
  logic         empty;
  logic         pop;

  always_comb begin
    in_entry      = '0;
    in_entry.addr = XLEN_MAX'(req_addr);
    in_entry.data = XLEN_MAX'(req_data);
    in_entry.size = req_size;
  end

  store_fifo #(
    .WIDTH($bits(store_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .wdata (in_entry),
    .full  (full),
    .pop   (pop),
    .rdata (head),
    .empty (empty)
  );

  assign req_ready = !full;
  assign busy      = !empty;

  // Head-entry alignment: build a two-word view so a crossing store's
  // spill into the next bus word falls out of the same shift.
  logic [XLEN-1:0]   h_addr;
  logic [XLEN-1:0]   h_data;
  logic [OFFW-1:0]   off;
  logic [1:0]        size_eff;
  logic [2*NB-1:0]   base;
  logic [2*NB-1:0]   mask;
  logic [2*XLEN-1:0] shifted;
  logic [2*XLEN-1:0] lane_data;
  logic [XLEN-1:0]   beat0_addr;
  logic [XLEN-1:0]   beat1_addr;
  logic              need1;
  logic              beat1_sel;
  logic              unused_head;

  assign h_addr      = head.addr[XLEN-1:0];
  assign h_data      = head.data[XLEN-1:0];
  assign unused_head = ^{head.addr, head.data};
  assign off         = h_addr[OFFW-1:0];
  assign size_eff    = (XLEN == 32 && head.size == SZ_D) ? SZ_W : head.size;
  assign beat0_addr  = {h_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign beat1_addr  = beat0_addr + XLEN'(NB);

  always_comb begin
    base = '0;
    case (size_eff)
      SZ_B:    base[0:0] = '1;
      SZ_H:    base[1:0] = '1;
      SZ_W:    base[3:0] = '1;
      default: base[7:0] = '1;
    endcase
    mask    = base << off;
    shifted = {{XLEN{1'b0}}, h_data} << {off, 3'b000};
    // Zero lanes outside the store so stray upper data bits never leak.
    for (int unsigned i = 0; i < 2*NB; i++) begin
      lane_data[8*i +: 8] = shifted[8*i +: 8] & {8{mask[i]}};
    end
  end

  assign need1 = |mask[2*NB-1:NB];

`ifdef WMEM_MISALIGNED_SPLIT_EN
  state_e state;

  assign beat1_sel    = (state == BEAT1);
  assign bus_valid    = beat1_sel || !empty;
  assign pop          = bus_valid && bus_ready && (beat1_sel || !need1);
  assign misalign_err = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BEAT0;
    end else begin
      case (state)
        BEAT0:   if (bus_valid && bus_ready && need1) state <= BEAT1;
        BEAT1:   if (bus_ready) state <= BEAT0;
        default: state <= BEAT0;
      endcase
    end
  end
`else
  // Crossing stores are discarded the cycle they reach the head.
  assign beat1_sel    = 1'b0;
  assign bus_valid    = !empty && !need1;
  assign misalign_err = !empty && need1;
  assign pop          = (bus_valid && bus_ready) || misalign_err;
`endif

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    bus_wstrb = '0;
    if (bus_valid) begin
      if (beat1_sel) begin
        bus_addr  = beat1_addr;
        bus_wdata = lane_data[2*XLEN-1:XLEN];
        bus_wstrb = mask[2*NB-1:NB];
      end else begin
        bus_addr  = beat0_addr;
        bus_wdata = lane_data[XLEN-1:0];
        bus_wstrb = mask[NB-1:0];
      end
    end
  end

endmodule

// File: tb/tb_wmem_store_unit.sv
module tb_wmem_store_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid32, req_ready32, bus_valid32, bus_ready32, busy32, merr32;
  logic [31:0] req_addr32, req_data32, bus_addr32, bus_wdata32;
  logic [1:0]  req_size32;
  logic [3:0]  bus_wstrb32;

  logic        req_valid64, req_ready64, bus_valid64, bus_ready64, busy64, merr64;
  logic [63:0] req_addr64, req_data64, bus_addr64, bus_wdata64;
  logic [1:0]  req_size64;
  logic [7:0]  bus_wstrb64;

  wmem_store_unit #(.XLEN(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid32), .req_ready(req_ready32),
    .req_addr(req_addr32), .req_data(req_data32), .req_size(req_size32),
    .bus_valid(bus_valid32), .bus_ready(bus_ready32),
    .bus_addr(bus_addr32), .bus_wdata(bus_wdata32), .bus_wstrb(bus_wstrb32),
    .busy(busy32), .misalign_err(merr32)
  );

  wmem_store_unit #(.XLEN(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid64), .req_ready(req_ready64),
    .req_addr(req_addr64), .req_data(req_data64), .req_size(req_size64),
    .bus_valid(bus_valid64), .bus_ready(bus_ready64),
    .bus_addr(bus_addr64), .bus_wdata(bus_wdata64), .bus_wstrb(bus_wstrb64),
    .busy(busy64), .misalign_err(merr64)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  estrb;
  } vec_t;

  vec_t tbl[6];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send32(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_addr32  = a;
    req_data32  = d;
    req_size32  = s;
    req_valid32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid32 = 1'b0;
  endtask

  task automatic send64(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
    req_addr64  = a;
    req_data64  = d;
    req_size64  = s;
    req_valid64 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid64 = 1'b0;
  endtask

  // Expected beat for backpressure request i: sb at 0x200+i with data 0x10+i.
  function automatic logic [31:0] bp_addr(input int i);
    return 32'h200 + ((i >= 4) ? 32'h4 : 32'h0);
  endfunction
  function automatic logic [31:0] bp_wdata(input int i);
    logic [31:0] v;
    v = 32'h10 + 32'(i);
    return v << (8 * (i % 4));
  endfunction
  function automatic logic [3:0] bp_strb(input int i);
    return 4'b0001 << (i % 4);
  endfunction

  task automatic chk_bp_fields(input int i, input string tag);
    chk({tag, " addr"},  64'(bus_addr32),  64'(bp_addr(i)));
    chk({tag, " wdata"}, 64'(bus_wdata32), 64'(bp_wdata(i)));
    chk({tag, " wstrb"}, 64'(bus_wstrb32), 64'(bp_strb(i)));
  endtask

  initial begin
    tbl[0] = '{32'h1003, 32'h0000_00AB, 2'b00, 32'h1000, 32'hAB00_0000, 4'b1000};
    tbl[1] = '{32'h1002, 32'h0000_1234, 2'b01, 32'h1000, 32'h1234_0000, 4'b1100};
    tbl[2] = '{32'h2000, 32'hDDCC_BBAA, 2'b10, 32'h2000, 32'hDDCC_BBAA, 4'b1111};
    tbl[3] = '{32'h0000, 32'hFFFF_FF5A, 2'b00, 32'h0000, 32'h0000_005A, 4'b0001};
    tbl[4] = '{32'h0011, 32'hFFFF_BEEF, 2'b01, 32'h0010, 32'h00BE_EF00, 4'b0110};
    tbl[5] = '{32'h0044, 32'h0102_0304, 2'b11, 32'h0044, 32'h0102_0304, 4'b1111};

    rst_n = 1'b0;
    req_valid32 = 1'b0; req_addr32 = '0; req_data32 = '0; req_size32 = '0; bus_ready32 = 1'b0;
    req_valid64 = 1'b0; req_addr64 = '0; req_data64 = '0; req_size64 = '0; bus_ready64 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst req_ready", 64'(req_ready32), 64'd1);
    chk("rst bus_valid", 64'(bus_valid32), 64'd0);
    chk("rst busy",      64'(busy32),      64'd0);
    chk("rst merr",      64'(merr32),      64'd0);
    chk("rst bus_addr",  64'(bus_addr32),  64'd0);
    chk("rst wdata",     64'(bus_wdata32), 64'd0);
    chk("rst wstrb",     64'(bus_wstrb32), 64'd0);
    chk("rst64 valid",   64'(bus_valid64), 64'd0);
    chk("rst64 ready",   64'(req_ready64), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-crossing stores from the table: one beat, valid the cycle after accept.
    for (int i = 0; i < 6; i++) begin
      bus_ready32 = 1'b0;
      chk($sformatf("v%0d req_ready", i), 64'(req_ready32), 64'd1);
      send32(tbl[i].addr, tbl[i].data, tbl[i].size);
      chk($sformatf("v%0d bus_valid", i), 64'(bus_valid32), 64'd1);
      chk($sformatf("v%0d bus_addr", i),  64'(bus_addr32),  64'(tbl[i].eaddr));
      chk($sformatf("v%0d wdata", i),     64'(bus_wdata32), 64'(tbl[i].edata));
      chk($sformatf("v%0d wstrb", i),     64'(bus_wstrb32), 64'(tbl[i].estrb));
      chk($sformatf("v%0d merr", i),      64'(merr32),      64'd0);
      bus_ready32 = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d drained busy", i),  64'(busy32),      64'd0);
      chk($sformatf("v%0d drained valid", i), 64'(bus_valid32), 64'd0);
    end

    // Word store crossing a bus-word boundary.
    bus_ready32 = 1'b1;
    send32(32'h2003, 32'hDDCC_BBAA, 2'b10);
`ifdef WMEM_MISALIGNED_SPLIT_EN
    chk("x beat0 valid", 64'(bus_valid32), 64'd1);
    chk("x beat0 addr",  64'(bus_addr32),  64'h2000);
    chk("x beat0 wdata", 64'(bus_wdata32), 64'hAA00_0000);
    chk("x beat0 wstrb", 64'(bus_wstrb32), 64'b1000);
    @(negedge clk);
    chk("x beat1 valid", 64'(bus_valid32), 64'd1);
    chk("x beat1 addr",  64'(bus_addr32),  64'h2004);
    chk("x beat1 wdata", 64'(bus_wdata32), 64'h00DD_CCBB);
    chk("x beat1 wstrb", 64'(bus_wstrb32), 64'b0111);
    chk("x beat1 busy",  64'(busy32),      64'd1);
    @(negedge clk);
    chk("x done busy",   64'(busy32),      64'd0);
    chk("x done valid",  64'(bus_valid32), 64'd0);
`else
    chk("x merr pulse",  64'(merr32),      64'd1);
    chk("x no beat",     64'(bus_valid32), 64'd0);
    @(negedge clk);
    chk("x merr clear",  64'(merr32),      64'd0);
    chk("x dropped busy", 64'(busy32),     64'd0);
    chk("x dropped valid", 64'(bus_valid32), 64'd0);
`endif

    // Backpressure: fill the FIFO, hold fields, then release one beat.
    bus_ready32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send32(32'h200 + 32'(i), 32'h10 + 32'(i), 2'b00);
    end
    chk("bp full req_ready", 64'(req_ready32), 64'd0);
    req_addr32  = 32'h204;
    req_data32  = 32'h14;
    req_size32  = 2'b00;
    req_valid32 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp hold%0d valid", k), 64'(bus_valid32), 64'd1);
      chk_bp_fields(0, $sformatf("bp hold%0d", k));
      @(negedge clk);
    end
    chk("bp still full", 64'(req_ready32), 64'd0);
    bus_ready32 = 1'b1;
    @(negedge clk);
    bus_ready32 = 1'b0;
    chk("bp ready after pop", 64'(req_ready32), 64'd1);
    chk_bp_fields(1, "bp after pop");
    @(negedge clk);
    req_valid32 = 1'b0;
    chk("bp refilled", 64'(req_ready32), 64'd0);
    bus_ready32 = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("bp drain%0d valid", i), 64'(bus_valid32), 64'd1);
      chk_bp_fields(i, $sformatf("bp drain%0d", i));
      @(negedge clk);
    end
    chk("bp drained busy", 64'(busy32), 64'd0);
    bus_ready32 = 1'b0;

    // XLEN=64 doubleword and upper-lane word.
    bus_ready64 = 1'b0;
    send64(64'h8, 64'h1122_3344_5566_7788, 2'b11);
    chk("d64 valid", 64'(bus_valid64), 64'd1);
    chk("d64 addr",  bus_addr64,       64'h8);
    chk("d64 wdata", bus_wdata64,      64'h1122_3344_5566_7788);
    chk("d64 wstrb", 64'(bus_wstrb64), 64'hFF);
    bus_ready64 = 1'b1;
    @(negedge clk);
    chk("d64 busy", 64'(busy64), 64'd0);
    bus_ready64 = 1'b0;
    send64(64'hC, 64'hCAFE_BABE, 2'b10);
    chk("w64 addr",  bus_addr64,       64'h8);
    chk("w64 wdata", bus_wdata64,      64'hCAFE_BABE_0000_0000);
    chk("w64 wstrb", 64'(bus_wstrb64), 64'hF0);
    bus_ready64 = 1'b1;
    @(negedge clk);
    bus_ready64 = 1'b0;

    // Reset with work pending (mid second beat when splitting is built in).
`ifdef WMEM_MISALIGNED_SPLIT_EN
    bus_ready32 = 1'b1;
    send32(32'h2003, 32'hDDCC_BBAA, 2'b10);
    req_addr32  = 32'h300;
    req_data32  = 32'h77;
    req_size32  = 2'b00;
    req_valid32 = 1'b1;
    @(negedge clk);
    req_valid32 = 1'b0;
    bus_ready32 = 1'b0;
    chk("mr beat1 addr", 64'(bus_addr32), 64'h2004);
`else
    bus_ready32 = 1'b0;
    send32(32'h300, 32'h77, 2'b00);
    send32(32'h301, 32'h78, 2'b00);
    chk("mr pending addr", 64'(bus_addr32), 64'h300);
`endif
    @(negedge clk);
    chk("mr pre valid", 64'(bus_valid32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr async valid", 64'(bus_valid32), 64'd0);
    chk("mr async busy",  64'(busy32),      64'd0);
    chk("mr async ready", 64'(req_ready32), 64'd1);
    chk("mr async wstrb", 64'(bus_wstrb32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ready32 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("mr quiet%0d valid", k), 64'(bus_valid32), 64'd0);
      chk($sformatf("mr quiet%0d busy", k),  64'(busy32),      64'd0);
    end
    bus_ready32 = 1'b0;
    send32(32'h1003, 32'hAB, 2'b00);
    chk("mr new valid", 64'(bus_valid32), 64'd1);
    chk("mr new addr",  64'(bus_addr32),  64'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
